snn_output_accum_ram: RTL and testbench

//  Parametrised 1-write/1-read output-unit memory for the SNN datapath. Stores one

---
 rtl/snn_ram_pkg.sv | 39 +++
 rtl/snn_ram_core.sv | 29 ++
 rtl/snn_output_accum_ram.sv | 133 +++++++++++++
 tb/tb_snn_output_accum_ram.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/snn_ram_pkg.sv
// Shared types, defaults and saturating-add helper for the SNN output accumulator RAM.
// Build option: define SNN_OUTPUT_RAM_SAT_EN to clamp overflowing accumulates instead of wrapping.
package snn_ram_pkg;

  localparam int unsigned DataWidthDef = 8;
  localparam int unsigned AddrWidthDef = 4;

`ifdef SNN_OUTPUT_RAM_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  typedef enum logic {CLEAR, RUN} ram_state_e;

  // Largest and smallest signed values representable in w bits.
  function automatic int sat_max(input int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int unsigned w);
    return -(1 << (w - 1));
  endfunction

  // The sum is exact in 32 bits; the caller truncates to w bits, which wraps when not clamped.
  function automatic int sat_add(input int a, input int b, input int unsigned w);
    int sum;
    sum = a + b;
    if (SatEn) begin
      if (sum > sat_max(w)) begin
        sum = sat_max(w);
      end else if (sum < sat_min(w)) begin
        sum = sat_min(w);
      end
    end
    return sum;
  endfunction

endpackage

// File: rtl/snn_ram_core.sv
// Storage array for the output accumulator: one synchronous write port, two async read ports.
module snn_ram_core #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr0,
  output logic [DATA_WIDTH-1:0] rdata0,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  output logic [DATA_WIDTH-1:0] rdata1
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/snn_output_accum_ram.sv
// Output-neuron score RAM: overwrite or accumulate writes through a 2-stage pipeline,
// self-clearing after reset. Build option: SNN_OUTPUT_RAM_SAT_EN selects saturating accumulate.
module snn_output_accum_ram
  import snn_ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned ADDR_WIDTH = AddrWidthDef
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  wr_acc,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  init_busy,
  output logic                  acc_ovf
);

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  logic                         s2_valid_q;
  logic                         s2_acc_q;
  logic [ADDR_WIDTH-1:0]        s2_addr_q;
  logic signed [DATA_WIDTH-1:0] s2_data_q;
  logic signed [DATA_WIDTH-1:0] s2_old_q;

  logic signed [DATA_WIDTH-1:0] mem_old, mem_rd;
  logic signed [DATA_WIDTH-1:0] s1_old, rd_val, commit_val;
  logic signed [DATA_WIDTH:0]   wide_sum;
  int                           sat_sum;
  logic                         ovf;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  running, wr_accept, rd_accept;

  assign running   = (state_q == RUN);
  assign init_busy = ~running;
  assign wr_accept = wr_en & running;
  assign rd_accept = rd_en & running;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  // S2 arithmetic: overflow from the extended sum, commit value optionally clamped.
  always_comb begin
    wide_sum   = {s2_old_q[DATA_WIDTH-1], s2_old_q} + {s2_data_q[DATA_WIDTH-1], s2_data_q};
    ovf        = wide_sum[DATA_WIDTH] ^ wide_sum[DATA_WIDTH-1];
    sat_sum    = sat_add(int'(s2_old_q), int'(s2_data_q), DATA_WIDTH);
    commit_val = s2_acc_q ? DATA_WIDTH'(sat_sum) : s2_data_q;
  end

  assign acc_ovf = s2_valid_q & s2_acc_q & ovf;

  // A commit in flight is newer than the array contents for both S1 and the read port.
  assign s1_old = (s2_valid_q && s2_addr_q == wr_addr) ? commit_val : mem_old;
  assign rd_val = (s2_valid_q && s2_addr_q == rd_addr) ? commit_val : mem_rd;

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = s2_addr_q;
    mem_wdata = commit_val;
    if (!rst) begin
      if (!running) begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
      end else begin
        mem_we = s2_valid_q;
      end
    end
  end

  snn_ram_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr0(wr_addr),
    .rdata0(mem_old),
    .raddr1(rd_addr),
    .rdata1(mem_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      s2_valid_q <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      s2_valid_q <= wr_accept;
      rd_valid   <= rd_accept;
      if (rd_accept) begin
        rd_data <= rd_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      s2_acc_q  <= wr_acc;
      s2_addr_q <= wr_addr;
      s2_data_q <= wr_data;
      s2_old_q  <= s1_old;
    end
  end

endmodule

// File: tb/tb_snn_output_accum_ram.sv
// Scoreboard bench for snn_output_accum_ram (8-bit data, 16 entries), both SAT_EN builds.
module tb_snn_output_accum_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       wr_acc = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       init_busy;
  logic       acc_ovf;

  int         n_checks = 0;
  int         n_pass = 0;
  int         ovf_seen = 0;
  logic [7:0] exp_q[$];

`ifdef SNN_OUTPUT_RAM_SAT_EN
  localparam logic [7:0] PosOvfExp = 8'h7F;
  localparam logic [7:0] NegOvfExp = 8'h80;
`else
  localparam logic [7:0] PosOvfExp = 8'h80;
  localparam logic [7:0] NegOvfExp = 8'h00;
`endif

  snn_output_accum_ram #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_acc   (wr_acc),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .init_busy(init_busy),
    .acc_ovf  (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest expected read.
  always @(negedge clk) begin
    if (acc_ovf === 1'b1) ovf_seen++;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rd_valid_unexpected", 1, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("rd_data", int'(rd_data), int'(e));
      end
    end
  end

  task automatic idle_inputs();
    wr_en = 1'b0;
    wr_acc = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic cyc(input bit we, input bit acc, input logic [3:0] wa, input logic [7:0] wd,
                     input bit re, input logic [3:0] ra, input logic [7:0] exp);
    wr_en = we;
    wr_acc = acc;
    wr_addr = wa;
    wr_data = wd;
    rd_en = re;
    rd_addr = ra;
    if (re) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, 4'(i), 8'h00);
    end
    idle(2);
  endtask

  // Reset, check reset state, then count busy cycles (optionally poking requests throughout).
  task automatic do_reset(input bit poke);
    int n;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_init_busy", int'(init_busy), 1);
    check("rst_acc_ovf", int'(acc_ovf), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst = 1'b0;
    if (poke) begin
      wr_en = 1'b1;
      wr_acc = 1'b1;
      wr_addr = 4'd1;
      wr_data = 8'h55;
      rd_en = 1'b1;
      rd_addr = 4'd1;
    end
    n = 0;
    while (init_busy === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    idle_inputs();
    check("busy_cycles", n, 16);
  endtask

  initial begin
    // 1: clear after reset, all entries zero
    do_reset(1'b0);
    read_all_zero();

    // 2: plain write then read next cycle
    cyc(1'b1, 1'b0, 4'd3, 8'h12, 1'b0, 4'd0, 8'h00);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd3, 8'h12);
    idle(2);

    // 3: back-to-back accumulates to one address
    cyc(1'b1, 1'b1, 4'd7, 8'h05, 1'b0, 4'd0, 8'h00);
    cyc(1'b1, 1'b1, 4'd7, 8'h05, 1'b0, 4'd0, 8'h00);
    cyc(1'b1, 1'b1, 4'd7, 8'h05, 1'b0, 4'd0, 8'h00);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd7, 8'h0F);
    idle(2);
    check("ovf_after_acc", ovf_seen, 0);

    // 4: positive and negative overflow
    cyc(1'b1, 1'b0, 4'd2, 8'h7F, 1'b0, 4'd0, 8'h00);
    cyc(1'b1, 1'b1, 4'd2, 8'h01, 1'b0, 4'd0, 8'h00);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, PosOvfExp);
    idle(2);
    check("ovf_pos", ovf_seen, 1);
    cyc(1'b1, 1'b0, 4'd4, 8'h80, 1'b0, 4'd0, 8'h00);
    cyc(1'b1, 1'b1, 4'd4, 8'h80, 1'b0, 4'd0, 8'h00);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd4, NegOvfExp);
    idle(2);
    check("ovf_neg", ovf_seen, 2);

    // Simultaneous write/read, read during commit, read of a just-accepted write
    cyc(1'b1, 1'b0, 4'd5, 8'h33, 1'b1, 4'd3, 8'h12);
    cyc(1'b1, 1'b0, 4'd6, 8'h21, 1'b1, 4'd5, 8'h33);
    cyc(1'b1, 1'b0, 4'd8, 8'h66, 1'b1, 4'd8, 8'h00);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd6, 8'h21);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd8, 8'h66);
    // Plain write over a large value never raises overflow
    cyc(1'b1, 1'b0, 4'd2, 8'h70, 1'b0, 4'd0, 8'h00);
    cyc(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd2, 8'h70);
    idle(2);
    check("ovf_plain", ovf_seen, 2);

    // 5: requests during the clear are dropped
    do_reset(1'b1);
    read_all_zero();

    // 6: reset with a write in flight, then reset again mid-clear
    cyc(1'b1, 1'b0, 4'd9, 8'h44, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(9);
    do_reset(1'b0);
    read_all_zero();

    idle(3);
    check("scoreboard_drained", exp_q.size(), 0);
    check("ovf_final", ovf_seen, 2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
